inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Parametrised instruction buffer between instruction-memory fetch and the decoder; successor to the single-entry instruction register.
- Holds up to DEPTH instructions, each tagged with its fetch PC.
- Uses valid/ready handshakes on both sides and supports a single-cycle flush on branch or redirect.
- Lets fetch run ahead of decode and absorbs decoder stalls without losing instructions.

Parameters:
- WIDTH, 16, instruction width in bits.
- PC_WIDTH, 16, width of the PC tag stored with each instruction.
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- NOP_INST, 16'h0000, value driven on out_inst whenever no instruction is presented.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-high; clock clock.
- flush  input  1  synchronous discard of all queued entries.
- in_valid  input  1  fetch presents in_inst/in_pc.
- in_ready  output  1  queue accepts a push this cycle.
- in_inst  input  WIDTH  instruction from memory.
- in_pc  input  PC_WIDTH  fetch address of in_inst.
- out_valid  output  1  out_inst/out_pc hold a valid instruction.
- out_ready  input  1  decoder consumes the presented instruction.
- out_inst  output  WIDTH  oldest instruction.
- out_pc  output  PC_WIDTH  PC of oldest instruction.
- count  output  $clog2(DEPTH)+1  number of stored entries.

Behaviour:
- Reset (async, immediate):
  - write pointer, read pointer and count go to 0.
  - out_valid=0, out_inst=NOP_INST, out_pc=0, in_ready=1.
  - Storage contents are don't-care.
- Push occurs when in_valid && in_ready. The entry is written at wr_ptr on the clock edge, and wr_ptr increments modulo DEPTH (natural wrap).
- Pop occurs when out_valid && out_ready. rd_ptr increments modulo DEPTH on the clock edge.
- in_ready = (count != DEPTH) && !flush. This is combinational from registered state and flush only; it never depends on out_ready.
- out_valid = (count != 0). out_inst/out_pc are read combinationally from the entry at rd_ptr.
- When count==0, out_inst=NOP_INST and out_pc=0.
- Latency: an instruction pushed at edge N is visible on out_* after edge N, i.e. in the following cycle (1-cycle latency).
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and both pointers advance.
- Full (count==DEPTH): in_ready=0 even if out_ready=1 that cycle. No same-cycle pass-through when full.
- Empty (count==0): no pop is possible; out_ready is ignored.
- Flush:
  - At the clock edge with flush=1, pointers and count go to 0.
  - Any push or pop in that cycle is cancelled. in_ready is already low, and a pop handshake in that cycle is discarded.
  - Next cycle: out_valid=0, out_inst=NOP_INST.
- Reset asserted mid-operation overrides everything, including flush, and clears the queue asynchronously.
- Input/output stability: out_* stay constant while out_valid=1 and out_ready=0, unless flush occurs.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- With the macro defined:
  - When count==0, in_valid=1, out_ready=1 and flush=0, the instruction passes combinationally: out_valid=1, out_inst=in_inst, out_pc=in_pc.
  - The handshake completes with no storage write, so count stays 0 (0-cycle latency).
  - If out_ready=0 in that situation, out_valid=1 still shows in_inst, and the normal push stores it.
- Without the macro: no combinational path from in_* to out_*; latency is always 1 cycle.

Test Plan:
1. Reset then idle: assert reset mid-cycle with no clock -> out_valid=0, out_inst=16'h0000, count=0, in_ready=1 immediately.
2. Fill and drain, DEPTH=4:
   - Push 16'hA001..16'hA004 with PCs 0x10..0x13 and out_ready=0 -> count=4, in_ready=0.
   - 5th push is held and not stored.
   - Then out_ready=1 -> outputs A001, A002, A003, A004 in order, with PCs 0x10..0x13.
3. Simultaneous push/pop at count=2 -> count stays 2 and order is preserved. Run 10 push/pop cycles to force pointer wrap; output sequence must match input sequence exactly.
4. Backpressure: out_ready held 0 for 3 cycles with out_valid=1 -> out_inst/out_pc unchanged for all 3 cycles.
5. Flush with 3 entries while in_valid=1 and out_ready=1 -> in_ready=0 that cycle, nothing consumed or stored. Next cycle count=0, out_valid=0, out_inst=NOP_INST.
6. Bypass: with INST_QUEUE_BYPASS_EN, push 16'hB00B while empty with out_ready=1 -> out_valid=1 and out_inst=B00B in the same cycle, count stays 0. Without the macro -> B00B appears one cycle later and count goes 1 then 0.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction buffer between fetch and decode: DEPTH entries tagged with fetch PC, valid/ready on both sides, single-cycle flush.
// Optional macro INST_QUEUE_BYPASS_EN adds a zero-latency combinational path from in_* to out_* when the queue is empty.
module inst_queue #(
    parameter int                 WIDTH    = 16,
    parameter int                 PC_WIDTH = 16,
    parameter int                 DEPTH    = 4,
    parameter logic [WIDTH-1:0]   NOP_INST = 16'h0000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_inst,
    input  logic [PC_WIDTH-1:0]          in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_inst,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("inst_queue: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0]    r_mem_inst [DEPTH];
    logic [PC_WIDTH-1:0] r_mem_pc   [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_bypass;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    assign in_ready = !w_full && !flush;
    assign count    = r_count;

`ifdef INST_QUEUE_BYPASS_EN
    // Empty queue with a waiting consumer: hand the instruction straight through, nothing is stored.
    assign w_bypass = w_empty && in_valid && out_ready && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = in_valid && in_ready && !w_bypass;
    assign w_pop  = out_ready && !w_empty && !flush;

    always_comb begin
        out_valid = !w_empty;
        out_inst  = NOP_INST;
        out_pc    = '0;
        if (!w_empty) begin
            out_inst = r_mem_inst[r_rd_ptr];
            out_pc   = r_mem_pc[r_rd_ptr];
        end
`ifdef INST_QUEUE_BYPASS_EN
        else if (in_valid && !flush) begin
            out_valid = 1'b1;
            out_inst  = in_inst;
            out_pc    = in_pc;
        end
`endif
    end

    // Storage carries no reset; contents are only observed once count says they are valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= in_inst;
            r_mem_pc[r_wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, fill/drain, push+pop wrap, backpressure, flush, bypass/latency.
module tb_inst_queue;
    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_inst;
    logic [15:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [15:0] out_pc;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    inst_queue #(.WIDTH(16), .PC_WIDTH(16), .DEPTH(4), .NOP_INST(16'h0000)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .count     (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 16'h0;
        in_pc     = 16'h0;
        out_ready = 1'b0;

        // reset asserted before any clock edge
        #3 reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst",  32'(out_inst),  32'h0000);
        check("rst_out_pc",    32'(out_pc),    32'h0000);
        check("rst_count",     32'(count),     32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        #10 reset = 1'b0;
        step();

        // fill to DEPTH with decoder stalled
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_inst  = 16'hA001 + 16'(i);
            in_pc    = 16'h0010 + 16'(i);
            step();
        end
        check("full_count",    32'(count),    32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head",     32'(out_inst), 32'hA001);
        in_inst = 16'hA005;
        in_pc   = 16'h0014;
        step();
        check("fifth_held_count", 32'(count), 32'd4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_inst",  32'(out_inst),  32'hA001 + 32'(i));
            check("drain_pc",    32'(out_pc),    32'h0010 + 32'(i));
            step();
        end
        check("drained_count", 32'(count),     32'd0);
        check("drained_valid", 32'(out_valid), 32'd0);
        check("drained_nop",   32'(out_inst),  32'h0000);

        // two entries, then concurrent push/pop across pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_inst  = 16'hC000 + 16'(i);
            in_pc    = 16'h0020 + 16'(i);
            step();
        end
        check("pp_pre_count", 32'(count), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_inst = 16'hC002 + 16'(i);
            in_pc   = 16'h0022 + 16'(i);
            #1;
            check("pp_inst", 32'(out_inst), 32'hC000 + 32'(i));
            check("pp_pc",   32'(out_pc),   32'h0020 + 32'(i));
            step();
            check("pp_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        check("pp_tail0", 32'(out_inst), 32'hC00A);
        step();
        check("pp_tail1", 32'(out_inst), 32'hC00B);
        check("pp_tail1_pc", 32'(out_pc), 32'h002B);
        step();
        check("pp_empty", 32'(count), 32'd0);

        // backpressure: head must hold for 3 stalled cycles
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_inst  = 16'hD001 + 16'(i);
            in_pc    = 16'h0030 + 16'(i);
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_inst",  32'(out_inst),  32'hD001);
            check("bp_pc",    32'(out_pc),    32'h0030);
        end
        in_valid = 1'b1;
        in_inst  = 16'hD003;
        in_pc    = 16'h0032;
        step();
        check("pre_flush_count", 32'(count), 32'd3);

        // flush with push and pop both requested
        in_inst   = 16'hE000;
        in_pc     = 16'h0040;
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("flush_count", 32'(count),     32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_nop",   32'(out_inst),  32'h0000);
        step();
        check("flush_nothing_stored", 32'(count), 32'd0);

        // push into empty queue with decoder ready
        in_valid  = 1'b1;
        in_inst   = 16'hB00B;
        in_pc     = 16'h0050;
        out_ready = 1'b1;
        #1;
`ifdef INST_QUEUE_BYPASS_EN
        check("byp_valid", 32'(out_valid), 32'd1);
        check("byp_inst",  32'(out_inst),  32'hB00B);
        check("byp_pc",    32'(out_pc),    32'h0050);
        step();
        in_valid = 1'b0;
        #1;
        check("byp_count", 32'(count),     32'd0);
        check("byp_after", 32'(out_valid), 32'd0);
`else
        check("lat_valid0", 32'(out_valid), 32'd0);
        check("lat_inst0",  32'(out_inst),  32'h0000);
        step();
        in_valid = 1'b0;
        #1;
        check("lat_count1", 32'(count),     32'd1);
        check("lat_valid1", 32'(out_valid), 32'd1);
        check("lat_inst1",  32'(out_inst),  32'hB00B);
        check("lat_pc1",    32'(out_pc),    32'h0050);
        step();
        check("lat_count0", 32'(count), 32'd0);
`endif

        // reset mid-operation overrides a pending flush and clears asynchronously
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 16'hF001;
        step();
        step();
        in_valid = 1'b0;
        flush    = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("midrst_count", 32'(count),     32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        #3 reset = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
